// File: rtl/port_frame_mux.sv
// ============================================================================
// Module  : port_frame_mux
// Moves the arbiter-granted port's frame into the shared egress FIFO, tagging
// each word with source port and express flag and truncating oversize frames.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module port_frame_mux #(
  parameter int PORT_NUM  = 10,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 1522,
  parameter int IDX_W     = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [PORT_NUM-1:0]        i_port_ack,
  input  logic                       i_port_vld,
  input  logic [7:0]                 i_port_qbu,
  input  logic [PORT_NUM*DATA_W-1:0] i_port_data,
  input  logic [PORT_NUM-1:0]        i_port_dvld,
  input  logic [PORT_NUM-1:0]        i_port_dlast,
  output logic [PORT_NUM-1:0]        o_port_rd,
  input  logic                       i_fifo_afull,
  output logic                       o_fifo_wr,
  output logic [DATA_W-1:0]          o_fifo_data,
  output logic                       o_fifo_last,
  output logic [IDX_W-1:0]           o_fifo_port,
  output logic                       o_fifo_qbu,
  output logic                       o_data_ready,
  output logic                       o_grant_err,
  output logic                       o_trunc_err
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                qbu_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                fifo_wr_q;
  logic [DATA_W-1:0]   fifo_data_q;
  logic                fifo_last_q;
  logic [IDX_W-1:0]    fifo_port_q;
  logic                fifo_qbu_q;
  logic                grant_err_q;
  logic                trunc_err_q;

  logic                gnt_one;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_qbu;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_dvld;
  logic                sel_dlast;
  logic                rd_en;
  logic                accept;
  logic                at_max;

  always_comb begin
    gnt_one   = ($countones(i_port_ack) == 1);
    gnt_idx   = '0;
    gnt_qbu   = 1'b0;
    sel_data  = '0;
    sel_dvld  = 1'b0;
    sel_dlast = 1'b0;
    o_port_rd = '0;
    // Reading is gated by reset so nothing is consumed while the frame is aborted.
    rd_en     = i_rst & (((state_q == S_XFER) & ~i_fifo_afull) | (state_q == S_DRAIN));
    for (int n = 0; n < PORT_NUM; n++) begin
      if (i_port_ack[n]) begin
        gnt_idx = IDX_W'(n);
      end
      if (idx_q == IDX_W'(n)) begin
        sel_data     = i_port_data[n*DATA_W +: DATA_W];
        sel_dvld     = i_port_dvld[n];
        sel_dlast    = i_port_dlast[n];
        o_port_rd[n] = rd_en;
      end
    end
    for (int n = 0; n < 8; n++) begin
      if (n < PORT_NUM && gnt_idx == IDX_W'(n)) begin
        gnt_qbu = i_port_qbu[n];
      end
    end
    accept = rd_en & sel_dvld;
    cnt_d  = (cnt_q == CNT_W'(MAX_BEATS)) ? cnt_q : cnt_q + CNT_W'(1);
    at_max = (cnt_d == CNT_W'(MAX_BEATS));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      qbu_q       <= 1'b0;
      cnt_q       <= '0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
      fifo_last_q <= 1'b0;
      fifo_port_q <= '0;
      fifo_qbu_q  <= 1'b0;
      grant_err_q <= 1'b0;
      trunc_err_q <= 1'b0;
    end else begin
      fifo_wr_q   <= 1'b0;
      fifo_last_q <= 1'b0;
      grant_err_q <= 1'b0;
      trunc_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_port_vld) begin
            if (gnt_one) begin
              idx_q   <= gnt_idx;
              qbu_q   <= gnt_qbu;
              cnt_q   <= '0;
              state_q <= S_XFER;
            end else begin
              grant_err_q <= 1'b1;
            end
          end
        end
        S_XFER: begin
          if (accept) begin
            fifo_wr_q   <= 1'b1;
            fifo_data_q <= sel_data;
            fifo_port_q <= idx_q;
            fifo_qbu_q  <= qbu_q;
            cnt_q       <= cnt_d;
            if (sel_dlast) begin
              fifo_last_q <= 1'b1;
              state_q     <= S_GAP;
            end else if (at_max) begin
              fifo_last_q <= 1'b1;
              trunc_err_q <= 1'b1;
              state_q     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (sel_dlast) begin
              state_q <= S_GAP;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_data_ready = i_rst & (state_q == S_IDLE) & ~i_fifo_afull;
  assign o_fifo_wr    = fifo_wr_q;
  assign o_fifo_data  = fifo_data_q;
  assign o_fifo_last  = fifo_last_q;
  assign o_fifo_port  = fifo_port_q;
  assign o_fifo_qbu   = fifo_qbu_q;
  assign o_grant_err  = grant_err_q;
  assign o_trunc_err  = trunc_err_q;

endmodule

`default_nettype wire

// File: doc/port_frame_mux.md
Name: port_frame_mux

Overview:
- Sits directly downstream of req_arbit.
- Consumes the one-hot grant (o_port_ack/o_port_vld) and moves the granted port's frame, beat by beat, into the shared egress FIFO.
- Returns i_data_ready to the arbiter: high only when idle and the FIFO has room.
- Enforces a maximum frame length and tags each FIFO word with source port and qbu (express) flag.

Parameters:
PORT_NUM, 10, number of requesting ports (ports 0-7 carry a qbu flag; 8-9 never express)
DATA_W, 8, data beat width
MAX_BEATS, 1522, maximum beats per frame before truncation
IDX_W, 4, width of the port index, ceil(log2(PORT_NUM))

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-low reset
i_port_ack  in  PORT_NUM  one-hot grant from arbiter
i_port_vld  in  1  grant valid, one-cycle pulse
i_port_qbu  in  8  qbu flag per port 0-7
i_port_data  in  PORT_NUM*DATA_W  per-port data, port n at bits [n*DATA_W +: DATA_W]
i_port_dvld  in  PORT_NUM  per-port beat valid
i_port_dlast  in  PORT_NUM  per-port last beat
o_port_rd  out  PORT_NUM  per-port read strobe; beat accepted when rd & dvld
i_fifo_afull  in  1  egress FIFO almost full, at least 2 free entries guaranteed while low
o_fifo_wr  out  1  FIFO write enable
o_fifo_data  out  DATA_W  FIFO write data
o_fifo_last  out  1  last beat of frame
o_fifo_port  out  IDX_W  source port index
o_fifo_qbu  out  1  express flag of the frame
o_data_ready  out  1  to arbiter i_data_ready: 1 = idle/free, 0 = busy
o_grant_err  out  1  one-cycle pulse on an illegal grant
o_trunc_err  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset (i_rst=0 at posedge): state IDLE, index 0, beat counter 0.
- All registered outputs reset to 0: o_fifo_*, o_grant_err, o_trunc_err.
- o_port_rd = 0. o_data_ready = 0 during reset and evaluates normally in the first cycle after reset releases.
- Reset mid-frame aborts the frame. No o_fifo_last is emitted.
- States:
  - IDLE: o_data_ready = ~i_fifo_afull (combinational from state and afull).
    - i_port_vld with exactly one ack bit set: latch index and qbu (qbu = 0 for ports 8-9), clear counter, go XFER.
    - i_port_vld with zero or multiple ack bits set: pulse o_grant_err next cycle, stay IDLE.
    - i_port_vld is ignored in every other state.
  - XFER: o_port_rd[idx] = ~i_fifo_afull; all other rd bits are 0.
    - Each accepted beat is registered onto the o_fifo_* outputs with o_fifo_wr = 1 one cycle later (latency 1). Counter increments.
    - Accepted beat with dlast: o_fifo_last = 1, go GAP.
    - Accepted beat where counter reaches MAX_BEATS without dlast: write it with o_fifo_last = 1 forced, pulse o_trunc_err, go DRAIN.
    - A beat with dlast exactly at MAX_BEATS is normal: no error.
  - DRAIN: o_port_rd[idx] = 1 regardless of afull. Beats are discarded (no FIFO write). Accepted dlast -> GAP.
  - GAP: one cycle with o_data_ready = 0 so the arbiter re-evaluates, then IDLE.
- o_data_ready = 0 in XFER, DRAIN and GAP.
- A new grant is accepted at the earliest 2 cycles after the last beat.
- Counter width is ceil(log2(MAX_BEATS+1)). It saturates and never wraps.
- dvld on non-granted ports is ignored.
- afull rising mid-frame stalls reading; no beat is lost or duplicated.

Test Plan:
- Grant ack=10'b00_0000_1000, port 3, qbu[3]=1, 4-beat frame 0xA1..0xA4 -> four FIFO writes 0xA1..0xA4, o_fifo_port=3, o_fifo_qbu=1, last on 4th write, o_data_ready low from the cycle after grant until 2 cycles after last.
- Grant port 9 with 3 beats, i_fifo_afull held high for 5 cycles after beat 1 -> o_port_rd[9]=0 during stall, exactly 3 writes in order, o_fifo_qbu=0.
- MAX_BEATS=16 override, port 0 frame of 20 beats -> 16 writes, last forced on write 16, o_trunc_err pulses once, 4 beats drained with no writes, then IDLE.
- Grant with ack=10'b00_0100_1011 (multi-bit) and with ack=0 -> o_grant_err pulse each, no rd, state stays IDLE, o_data_ready stays 1.
- i_rst driven low during beat 2 of a 6-beat frame -> next cycle all outputs 0, state IDLE; a subsequent grant to port 5 transfers normally.
- Back-to-back: port 2 frame, then port 6 granted on the first cycle o_data_ready returns high -> two frames in FIFO, correct port tags, no beat interleaving.
